slave_spi4post: RTL
===================

SLAVE_SPI4POST -- requirements
Module: slave_spi4post

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flip-flop depth on CS, SCK and MOSI (minimum 2).
REQ-002 SHALL have port CLK, input, 1, system clock; single clock domain.
REQ-003 SHALL have port RST, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port CS, input, 1, SPI chip select from master, active-low, asynchronous to CLK.
REQ-005 SHALL have port SCK, input, 1, SPI clock from master, idles high, asynchronous to CLK.
REQ-006 SHALL have port MOSI, input, 1, serial data from master, MSB first.
REQ-007 SHALL have port MISO, output, 1, serial data to master, MSB first.
REQ-008 SHALL have port Tx_word, input, 16, word to return to master, captured at frame start.
REQ-009 SHALL have port Rx_word, output, 16, last complete word received.
REQ-010 SHALL have port Rx_valid, output, 1, one-CLK pulse when Rx_word updates.
REQ-011 SHALL have port Abort, output, 1, one-CLK pulse when a frame ends before 16 bits.
REQ-012 SHALL have port Busy, output, 1, high while a frame is in progress.

Function
REQ-013 SHALL implement SPI with SCK idle high: master changes MOSI while SCK low, both sides sample on SCK rising edge, slave changes MISO on SCK falling edge; 16-bit frames.
REQ-014 SHALL pass CS, SCK and MOSI through SYNC_STAGES flip-flops and one edge-detect register each; MOSI delay SHALL equal SCK delay.
REQ-015 SHALL operate correctly for f_SCK <= CLK/8 with SCK high and low phases each >= 3 CLK periods.
REQ-016 SHALL use FSM states IDLE, LOAD, SHIFT, DONE, WAIT_CS.
REQ-017 IDLE: Busy=0, MISO=1; synchronized CS falling edge -> LOAD.
REQ-018 LOAD (1 cycle): capture Tx_word into output shift register, clear input shift register and 5-bit bit counter, drive MISO=Tx_word[15], Busy=1 -> SHIFT.
REQ-019 SHIFT: on synchronized SCK rising edge, shift synchronized MOSI into input register LSB and increment bit counter.
REQ-020 SHIFT: on synchronized SCK falling edge with bit counter 1..15, shift output register left and drive MISO with new MSB; falling edges at counter 0 (coincident with CS fall) SHALL be ignored.
REQ-021 SHIFT: when bit counter reaches 16 -> DONE.
REQ-022 DONE (1 cycle): Rx_word <= input register, Rx_valid=1 -> WAIT_CS.
REQ-023 WAIT_CS: MISO=1; further SCK edges ignored; Busy stays 1; CS rising edge -> IDLE.
REQ-024 Rx_valid SHALL assert exactly 2 CLK cycles after the synchronized 16th SCK rising edge is detected.
REQ-025 CS rising edge in LOAD or SHIFT -> IDLE, Abort=1 for one cycle, Rx_word unchanged, no Rx_valid.
REQ-026 CS rise and 16th SCK rise detected in the same cycle: completed frame wins, DONE then IDLE, no Abort.
REQ-027 Tx_word changes after LOAD SHALL NOT affect the frame in progress.
REQ-028 Busy SHALL fall in the cycle the FSM enters IDLE.

Reset
REQ-029 RST low SHALL immediately force: FSM=IDLE, MISO=1, Rx_word=0, Rx_valid=0, Abort=0, Busy=0, shift registers and bit counter 0.
REQ-030 During reset, synchronizer and edge registers SHALL load idle levels (CS=1, SCK=1, MOSI=1) so reset release causes no false edge.
REQ-031 Reset asserted mid-frame SHALL discard the frame without Rx_valid or Abort; the next CS fall after release starts a new frame.

Verification
REQ-032 Master at CLK/8 sends 0xA5C3, Tx_word=0x3C5A -> Rx_word=0xA5C3, one Rx_valid pulse, master receives 0x3C5A.
REQ-033 Back-to-back frames 0xFFFF then 0x0001 (Tx_word 0x0000 then 0x8000) -> two Rx_valid pulses, Rx_word 0xFFFF then 0x0001, master receives 0x0000 then 0x8000.
REQ-034 CS raised after 7 SCK rising edges -> one Abort pulse, no Rx_valid, Rx_word keeps previous value, Busy low, MISO=1.
REQ-035 Tx_word toggled every CLK during frame after LOAD -> master receives value captured at LOAD.
REQ-036 RST asserted after 10 bits, released, then full frame 0x1234 -> no pulse from aborted frame, Rx_word=0x1234 with one Rx_valid.
REQ-037 Extra 3 SCK cycles after 16th bit before CS rise -> single Rx_valid, MISO=1, Rx_word unchanged by extra edges.

Source files
------------

// File: rtl/slave_spi4post.sv
// slave_spi4post: 16-bit SPI slave (SCK idle high, sample on rise, shift on fall)
// oversampled in the CLK domain through synchronizers and edge detectors.
module slave_spi4post #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        SCK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] Tx_word,
  output logic [15:0] Rx_word,
  output logic        Rx_valid,
  output logic        Abort,
  output logic        Busy
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, WAIT_CS} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0][2:0] sync;
  logic cs_p, sck_p;
  logic cs_s, sck_s, mosi_s;
  logic cs_fall, cs_rise, sck_fall, sck_rise;
  logic [15:0] rx_sr;
  logic [14:0] tx_sr;
  logic [4:0] cnt;
  // MOSI is sampled at the last sync stage, the same depth the SCK edge is detected at
  assign {cs_s, sck_s, mosi_s} = sync[SYNC_STAGES-1];
  assign cs_fall = cs_p & ~cs_s;
  assign cs_rise = ~cs_p & cs_s;
  assign sck_fall = sck_p & ~sck_s;
  assign sck_rise = ~sck_p & sck_s;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync <= '1;
      cs_p <= 1'b1;
      sck_p <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], {CS, SCK, MOSI}};
      cs_p <= cs_s;
      sck_p <= sck_s;
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      MISO <= 1'b1;
      Rx_word <= '0;
      Rx_valid <= 1'b0;
      Abort <= 1'b0;
      Busy <= 1'b0;
      rx_sr <= '0;
      tx_sr <= '0;
      cnt <= '0;
    end else begin
      Rx_valid <= 1'b0;
      Abort <= 1'b0;
      case (state)
        IDLE: begin
          MISO <= 1'b1;
          Busy <= cs_fall;
          if (cs_fall) state <= LOAD;
        end
        LOAD: begin
          if (cs_rise) begin
            state <= IDLE;
            Abort <= 1'b1;
            Busy <= 1'b0;
            MISO <= 1'b1;
          end else begin
            state <= SHIFT;
            MISO <= Tx_word[15];
            tx_sr <= Tx_word[14:0];
            rx_sr <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          if (cnt == 5'd16) begin
            state <= DONE;
            Rx_word <= rx_sr;
            Rx_valid <= 1'b1;
            MISO <= 1'b1;
          end else if (cs_rise && !(sck_rise && cnt == 5'd15)) begin
            state <= IDLE;
            Abort <= 1'b1;
            Busy <= 1'b0;
            MISO <= 1'b1;
          end else begin
            if (sck_rise) begin
              rx_sr <= {rx_sr[14:0], mosi_s};
              cnt <= cnt + 5'd1;
            end
            // the fall at count 0 belongs to frame start; MISO already holds bit 15
            if (sck_fall && cnt != 5'd0) begin
              MISO <= tx_sr[14];
              tx_sr <= {tx_sr[13:0], 1'b0};
            end
          end
        end
        DONE: begin
          // CS may already be high if it rose together with the last SCK edge
          state <= cs_s ? IDLE : WAIT_CS;
          Busy <= ~cs_s;
          MISO <= 1'b1;
        end
        WAIT_CS: begin
          MISO <= 1'b1;
          if (cs_rise) begin
            state <= IDLE;
            Busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy <= 1'b0;
          MISO <= 1'b1;
        end
      endcase
    end
  end
endmodule
